// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: halt opcode, bubble instruction, default reset PC, fetch FSM encoding.
// No logic of its own; consumed by if_stage and if_id_reg.
// No flow control here; see the stage modules.
package mips_pkg;

    localparam logic [5:0]  OPC_HALT         = 6'b101101;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Instruction fetches are always word aligned; drop the byte offset.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: carries fetched instruction, its PC+4 and a valid flag into decode.
// Latency: one clk from load to output.
// Backpressure: neither load nor flush asserted holds contents; flush beats load and writes a bubble.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] next_inst,
    input  logic [31:0] next_pc4,
    output logic [31:0] inst,
    output logic [31:0] pc4,
    output logic        valid
);

    // Bubble on reset or flush, capture on load, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst  <= NOP_INST;
            pc4   <= 32'h0000_0000;
            valid <= 1'b0;
        end else if (flush) begin
            inst  <= NOP_INST;
            pc4   <= 32'h0000_0000;
            valid <= 1'b0;
        end else if (load) begin
            inst  <= next_inst;
            pc4   <= next_pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, next-PC selection, BOOT/RUN/HALTED fetch FSM, IF/ID register.
// Latency: inst_in sampled at PC appears on ifid_inst one clk later; first fetch two edges after reset release.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall and flushes. Halt detect gated by IF_HALT_DETECT_EN.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [5:0]  HALT_OPCODE = OPC_HALT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_in,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted
);

`ifdef IF_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_state_t state;
    fetch_state_t next_state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic         halt_hit;
    logic         ifid_load;
    logic         ifid_flush;
    logic         unused_offset;

    assign pc_plus4      = pc + 32'd4;
    assign inst_addr     = pc;
    assign halt_hit      = HALT_EN && (inst_in[31:26] == HALT_OPCODE);
    // Byte offset of a redirect target is deliberately discarded.
    assign unused_offset = ^redirect_pc[1:0];

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: BOOT is a single cycle; HALTED is left only through reset.
    always_comb begin
        next_state = state;
        case (state)
            BOOT:    next_state = RUN;
            RUN:     if (!redirect && !stall && halt_hit) next_state = HALTED;
            HALTED:  next_state = HALTED;
            default: next_state = BOOT;
        endcase
    end

    // Output decode: PC source and IF/ID control per state; redirect beats stall and halt.
    always_comb begin
        pc_next    = pc;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state)
            BOOT: begin
                ifid_flush = 1'b1;
            end
            RUN: begin
                if (redirect) begin
                    pc_next    = word_align(redirect_pc);
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    // A halt is still handed to decode, but the PC freezes on it.
                    if (!halt_hit) begin
                        pc_next = pc_plus4;
                    end
                end
            end
            HALTED: begin
                ifid_flush = 1'b1;
            end
            default: begin
                ifid_flush = 1'b1;
            end
        endcase
    end

    // Program counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

`ifdef IF_HALT_DETECT_EN
    assign halted = (state == HALTED);
`else
    assign halted = 1'b0;
`endif

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (ifid_load),
        .flush     (ifid_flush),
        .next_inst (inst_in),
        .next_pc4  (pc_plus4),
        .inst      (ifid_inst),
        .pc4       (ifid_pc4),
        .valid     (ifid_valid)
    );

endmodule
